// File: rtl/cardinal_nic_pkg.sv
// rtl/cardinal_nic_pkg.sv - NIC register map, status bit and access FSM states
//
// Shared by cardinal_nic_arbiter. No ports.
package cardinal_nic_pkg;

    localparam logic [1:0] NIC_RX_DATA = 2'b00;  // input buffer data, read clears
    localparam logic [1:0] NIC_RX_STAT = 2'b01;  // input buffer status
    localparam logic [1:0] NIC_TX_DATA = 2'b10;  // output buffer data, write
    localparam logic [1:0] NIC_TX_STAT = 2'b11;  // output buffer status

    localparam int STATUS_BIT = 63;

    typedef enum logic [1:0] {
        RX_STAT  = 2'd0,
        RX_READ  = 2'd1,
        TX_STAT  = 2'd2,
        TX_WRITE = 2'd3
    } nic_state_t;

endpackage

// File: rtl/cardinal_nic_arbiter_rr_arbiter.sv
// rtl/cardinal_nic_arbiter_rr_arbiter.sv - combinational round-robin winner select
//
// Ports:
//   req_valid  in   NUM_REQ  per-requester request
//   ptr        in   IDW      highest-priority index this round
//   gnt        out  IDW      first asserted request at or after ptr (wrapping)
//   gnt_valid  out  1        any request asserted
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDW-1:0]     ptr,
    output logic [IDW-1:0]     gnt,
    output logic               gnt_valid
);

    logic [IDW-1:0] idx;

    // Scan from the farthest offset down to offset 0 so the candidate
    // closest to the pointer is the last (winning) assignment.
    always_comb begin
        gnt       = '0;
        gnt_valid = 1'b0;
        idx       = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = IDW'((int'(ptr) + i) % NUM_REQ);
            if (req_valid[idx]) begin
                gnt       = idx;
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cardinal_nic_arbiter.sv
// rtl/cardinal_nic_arbiter.sv - round-robin TX sharing and RX holding for the NIC register port
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   req_valid/data    NUM_REQ transmit requesters, packed DATA_WIDTH packets
//   req_ready         one-hot accept pulse in the NIC write cycle
//   rx_valid/data     one-entry receive holding register, drained by rx_ready
//   addr, d_in, d_out NIC register select, write data, read data
//   nicEn, nicEnWr    NIC access / write enable
//   grant_id          index of the last granted requester
module cardinal_nic_arbiter
    import cardinal_nic_pkg::*;
#(
    parameter  int DATA_WIDTH = 64,
    parameter  int NUM_REQ    = 4,
    localparam int IDW        = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          rx_valid,
    output logic [DATA_WIDTH-1:0]         rx_data,
    input  logic                          rx_ready,
    output logic [1:0]                    addr,
    output logic [DATA_WIDTH-1:0]         d_in,
    input  logic [DATA_WIDTH-1:0]         d_out,
    output logic                          nicEn,
    output logic                          nicEnWr,
    output logic [IDW-1:0]                grant_id
);

    // Status flag is the top data bit; matches STATUS_BIT for 64-bit packets.
    localparam int SB = (DATA_WIDTH == 64) ? STATUS_BIT : DATA_WIDTH - 1;

    nic_state_t     state, next_state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] gnt;
    logic [IDW-1:0] arb_gnt;
    logic           arb_valid;
    logic           tx_go;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req_valid (req_valid),
        .ptr       (ptr),
        .gnt       (arb_gnt),
        .gnt_valid (arb_valid)
    );

    assign tx_go = (state == TX_STAT) && !d_out[SB] && arb_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RX_STAT;
            ptr      <= '0;
            gnt      <= '0;
            grant_id <= '0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
        end else begin
            state <= next_state;
            // RX_READ is only entered with the holding register empty,
            // so the capture never competes with a consumer drain.
            if (state == RX_READ) begin
                rx_data  <= d_out;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (tx_go) begin
                gnt <= arb_gnt;
            end
            if (state == TX_WRITE) begin
                grant_id <= gnt;
                ptr      <= (gnt == IDW'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        addr       = NIC_RX_STAT;
        nicEn      = 1'b1;
        nicEnWr    = 1'b0;
        d_in       = '0;
        req_ready  = '0;
        case (state)
            RX_STAT: begin
                addr       = NIC_RX_STAT;
                next_state = (d_out[SB] && !rx_valid) ? RX_READ : TX_STAT;
            end
            RX_READ: begin
                addr       = NIC_RX_DATA;
                next_state = TX_STAT;
            end
            TX_STAT: begin
                addr       = NIC_TX_STAT;
                next_state = tx_go ? TX_WRITE : RX_STAT;
            end
            TX_WRITE: begin
                addr           = NIC_TX_DATA;
                nicEnWr        = 1'b1;
                d_in           = req_data[gnt*DATA_WIDTH +: DATA_WIDTH];
                req_ready[gnt] = 1'b1;
                next_state     = RX_STAT;
            end
            default: next_state = RX_STAT;
        endcase
        // Suppress any NIC side effect (write or read-clear) during reset.
        if (reset) begin
            nicEn     = 1'b0;
            nicEnWr   = 1'b0;
            req_ready = '0;
            addr      = NIC_RX_DATA;
            d_in      = '0;
        end
    end

endmodule

// File: tb/tb_cardinal_nic_arbiter.sv
// tb/tb_cardinal_nic_arbiter.sv - self-checking bench for cardinal_nic_arbiter
module tb_cardinal_nic_arbiter;

    localparam int W = 64;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           rx_valid;
    logic [W-1:0]   rx_data;
    logic           rx_ready;
    logic [1:0]     addr;
    logic [W-1:0]   d_in;
    logic [W-1:0]   d_out;
    logic           nicEn;
    logic           nicEnWr;
    logic [1:0]     grant_id;

    // NIC model state
    logic           in_full;
    logic [W-1:0]   in_data;
    logic           out_full;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cardinal_nic_arbiter #(.DATA_WIDTH(W), .NUM_REQ(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .addr      (addr),
        .d_in      (d_in),
        .d_out     (d_out),
        .nicEn     (nicEn),
        .nicEnWr   (nicEnWr),
        .grant_id  (grant_id)
    );

    always_comb begin
        case (addr)
            2'b00:   d_out = in_data;
            2'b01:   d_out = {in_full, 63'b0};
            2'b10:   d_out = '0;
            default: d_out = {out_full, 63'b0};
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- table-driven directed sequence ----------------
    typedef struct {
        logic       rst;
        logic [3:0] rv;
        logic       ofull;
        logic       ifull;
        logic       rrdy;
        logic [1:0] addr;
        logic       en;
        logic       wr;
        logic [3:0] rr;
        logic [63:0] din;
        logic [1:0] gid;
        logic       rxv;
    } vec_t;

    vec_t tbl [30];

    function automatic vec_t mk(input logic rst, input logic [3:0] rv, input logic ofull,
                                input logic ifull, input logic rrdy, input logic [1:0] a,
                                input logic en, input logic wr, input logic [3:0] rr,
                                input logic [63:0] din, input logic [1:0] gid, input logic rxv);
        vec_t v;
        v.rst = rst; v.rv = rv; v.ofull = ofull; v.ifull = ifull; v.rrdy = rrdy;
        v.addr = a; v.en = en; v.wr = wr; v.rr = rr; v.din = din; v.gid = gid; v.rxv = rxv;
        return v;
    endfunction

    // ---------------- traffic engine with reference model ----------------
    logic [W-1:0] tx_pkts [N][16];
    int           tx_cnt  [N];
    int           sent    [N];
    logic [W-1:0] rx_pkts [32];
    int           rx_n, rx_loaded, rx_got;
    int           mptr;
    logic [N-1:0] prev_valid;
    logic [1:0]   prev_addr;
    logic         prev_ofull;
    logic         pop_pending;
    logic [N-1:0] drop;
    bit           rand_mode;

    function automatic int winner(input logic [N-1:0] v, input int p);
        for (int d = 0; d < N; d++) begin
            if (v[(p + d) % N]) return (p + d) % N;
        end
        return -1;
    endfunction

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            if (!req_valid[k] && sent[k] < tx_cnt[k] && (!rand_mode || $urandom_range(0, 2) == 0)) begin
                req_valid[k]        = 1'b1;
                req_data[k*W +: W]  = tx_pkts[k][sent[k]];
            end
        end
        if (!in_full && rx_loaded < rx_n && (!rand_mode || $urandom_range(0, 1) == 0)) begin
            in_full = 1'b1;
            in_data = rx_pkts[rx_loaded];
            rx_loaded++;
        end
        rx_ready = rand_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
        out_full = rand_mode ? ($urandom_range(0, 3) == 0) : 1'b0;
    endtask

    task automatic monitor();
        int k;
        int w;
        if (req_ready != '0) begin
            k = -1;
            for (int i = 0; i < N; i++) if (req_ready[i]) k = i;
            chk("ready_onehot", 64'($countones(req_ready)), 64'd1);
            chk("ready_with_write", 64'({nicEnWr, addr}), 64'(3'b110));
            chk("grant_follows_tx_stat", 64'({prev_addr, prev_ofull}), 64'(3'b110));
            w = winner(prev_valid, mptr);
            chk("rr_winner", 64'(k), 64'(w));
            if (k >= 0 && sent[k] < tx_cnt[k]) begin
                chk("tx_data", d_in, tx_pkts[k][sent[k]]);
                sent[k]++;
                drop[k] = 1'b1;
            end
            if (w >= 0) mptr = (w + 1) % N;
        end else if (nicEnWr) begin
            chk("write_without_ready", 64'(nicEnWr), 64'd0);
        end
        if (nicEn && !nicEnWr && addr == 2'b00) begin
            chk("read_only_when_full", 64'(in_full), 64'd1);
            pop_pending = 1'b1;
        end
        if (rx_valid && rx_ready) begin
            if (rx_got < rx_n) chk("rx_data", rx_data, rx_pkts[rx_got]);
            else chk("rx_extra", 64'(rx_got), 64'(rx_n - 1));
            rx_got++;
        end
        prev_valid = req_valid;
        prev_addr  = addr;
        prev_ofull = out_full;
    endtask

    task automatic post_edge();
        if (pop_pending) begin
            in_full     = 1'b0;
            pop_pending = 1'b0;
        end
        for (int k = 0; k < N; k++) begin
            if (drop[k]) begin
                req_valid[k] = 1'b0;
                drop[k]      = 1'b0;
            end
        end
    endtask

    task automatic run_engine(input int limit);
        int cyc;
        int tot_sent;
        int tot_cnt;
        reset = 1'b1; req_valid = '0; rx_ready = 1'b0; out_full = 1'b0;
        in_full = 1'b0; in_data = '0;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
        mptr = 0; prev_valid = '0; prev_addr = 2'b00; prev_ofull = 1'b0;
        pop_pending = 1'b0; drop = '0; rx_loaded = 0; rx_got = 0;
        for (int k = 0; k < N; k++) sent[k] = 0;
        cyc = 0;
        while (cyc < limit) begin
            tot_sent = 0; tot_cnt = 0;
            for (int k = 0; k < N; k++) begin tot_sent += sent[k]; tot_cnt += tx_cnt[k]; end
            if (tot_sent == tot_cnt && rx_got == rx_n) break;
            drive();
            @(negedge clk);
            monitor();
            @(posedge clk); #1;
            post_edge();
            cyc++;
        end
        tot_sent = 0; tot_cnt = 0;
        for (int k = 0; k < N; k++) begin tot_sent += sent[k]; tot_cnt += tx_cnt[k]; end
        chk("all_tx_delivered", 64'(tot_sent), 64'(tot_cnt));
        chk("all_rx_delivered", 64'(rx_got), 64'(rx_n));
    endtask

    initial begin
        // Requester packets for the directed sequence; requester 2 carries 0xA5.
        reset = 1'b1; req_valid = '0; rx_ready = 1'b0; out_full = 1'b0;
        in_full = 1'b0; in_data = 64'h1;
        req_data[0*W +: W] = 64'h100;
        req_data[1*W +: W] = 64'h101;
        req_data[2*W +: W] = 64'hA5;
        req_data[3*W +: W] = 64'h103;

        //             rst rv     of if rr   addr   en wr rdy     din     gid rxv
        tbl[0]  = mk(1, 4'b0000, 0, 0, 0, 2'b00, 0, 0, 4'b0000, 64'h0,   0, 0);
        tbl[1]  = mk(1, 4'b0000, 0, 0, 0, 2'b00, 0, 0, 4'b0000, 64'h0,   0, 0);
        tbl[2]  = mk(0, 4'b0100, 0, 0, 0, 2'b01, 1, 0, 4'b0000, 64'h0,   0, 0);
        tbl[3]  = mk(0, 4'b0100, 0, 0, 0, 2'b11, 1, 0, 4'b0000, 64'h0,   0, 0);
        tbl[4]  = mk(0, 4'b0100, 0, 0, 0, 2'b10, 1, 1, 4'b0100, 64'hA5,  0, 0);
        tbl[5]  = mk(0, 4'b0000, 0, 0, 0, 2'b01, 1, 0, 4'b0000, 64'h0,   2, 0);
        tbl[6]  = mk(0, 4'b1111, 0, 0, 0, 2'b11, 1, 0, 4'b0000, 64'h0,   2, 0);
        tbl[7]  = mk(0, 4'b1111, 0, 0, 0, 2'b10, 1, 1, 4'b1000, 64'h103, 2, 0);
        tbl[8]  = mk(0, 4'b1111, 0, 0, 0, 2'b01, 1, 0, 4'b0000, 64'h0,   3, 0);
        tbl[9]  = mk(0, 4'b1111, 0, 0, 0, 2'b11, 1, 0, 4'b0000, 64'h0,   3, 0);
        tbl[10] = mk(0, 4'b1111, 0, 0, 0, 2'b10, 1, 1, 4'b0001, 64'h100, 3, 0);
        tbl[11] = mk(0, 4'b1111, 0, 0, 0, 2'b01, 1, 0, 4'b0000, 64'h0,   0, 0);
        tbl[12] = mk(0, 4'b1111, 0, 0, 0, 2'b11, 1, 0, 4'b0000, 64'h0,   0, 0);
        tbl[13] = mk(0, 4'b1111, 0, 0, 0, 2'b10, 1, 1, 4'b0010, 64'h101, 0, 0);
        tbl[14] = mk(0, 4'b1111, 0, 0, 0, 2'b01, 1, 0, 4'b0000, 64'h0,   1, 0);
        tbl[15] = mk(0, 4'b1111, 1, 0, 0, 2'b11, 1, 0, 4'b0000, 64'h0,   1, 0);
        tbl[16] = mk(0, 4'b1111, 1, 0, 0, 2'b01, 1, 0, 4'b0000, 64'h0,   1, 0);
        tbl[17] = mk(0, 4'b1111, 1, 0, 0, 2'b11, 1, 0, 4'b0000, 64'h0,   1, 0);
        tbl[18] = mk(0, 4'b1111, 0, 1, 0, 2'b01, 1, 0, 4'b0000, 64'h0,   1, 0);
        tbl[19] = mk(0, 4'b1111, 0, 1, 0, 2'b00, 1, 0, 4'b0000, 64'h0,   1, 0);
        tbl[20] = mk(0, 4'b1111, 0, 1, 0, 2'b11, 1, 0, 4'b0000, 64'h0,   1, 1);
        tbl[21] = mk(0, 4'b1111, 0, 1, 0, 2'b10, 1, 1, 4'b0100, 64'hA5,  1, 1);
        tbl[22] = mk(0, 4'b1111, 0, 1, 1, 2'b01, 1, 0, 4'b0000, 64'h0,   2, 1);
        tbl[23] = mk(0, 4'b1111, 0, 1, 0, 2'b11, 1, 0, 4'b0000, 64'h0,   2, 0);
        tbl[24] = mk(1, 4'b1111, 0, 1, 0, 2'b00, 0, 0, 4'b0000, 64'h0,   2, 0);
        tbl[25] = mk(0, 4'b1111, 0, 1, 0, 2'b01, 1, 0, 4'b0000, 64'h0,   0, 0);
        tbl[26] = mk(0, 4'b1111, 0, 1, 0, 2'b00, 1, 0, 4'b0000, 64'h0,   0, 0);
        tbl[27] = mk(0, 4'b1111, 0, 0, 0, 2'b11, 1, 0, 4'b0000, 64'h0,   0, 1);
        tbl[28] = mk(0, 4'b1111, 0, 0, 0, 2'b10, 1, 1, 4'b0001, 64'h100, 0, 1);
        tbl[29] = mk(0, 4'b0000, 0, 0, 0, 2'b01, 1, 0, 4'b0000, 64'h0,   0, 1);

        repeat (2) begin @(posedge clk); #1; end

        for (int i = 0; i < 30; i++) begin
            reset     = tbl[i].rst;
            req_valid = tbl[i].rv;
            out_full  = tbl[i].ofull;
            in_full   = tbl[i].ifull;
            rx_ready  = tbl[i].rrdy;
            @(negedge clk);
            chk($sformatf("vec%0d_addr", i),      64'(addr),      64'(tbl[i].addr));
            chk($sformatf("vec%0d_nicEn", i),     64'(nicEn),     64'(tbl[i].en));
            chk($sformatf("vec%0d_nicEnWr", i),   64'(nicEnWr),   64'(tbl[i].wr));
            chk($sformatf("vec%0d_req_ready", i), 64'(req_ready), 64'(tbl[i].rr));
            chk($sformatf("vec%0d_d_in", i),      d_in,           tbl[i].din);
            chk($sformatf("vec%0d_grant_id", i),  64'(grant_id),  64'(tbl[i].gid));
            chk($sformatf("vec%0d_rx_valid", i),  64'(rx_valid),  64'(tbl[i].rxv));
            @(posedge clk); #1;
        end
        chk("rx_data_captured", rx_data, 64'h1);

        // Mixed traffic: 10 RX packets 1..10, 5+5 TX packets from requesters 0 and 1.
        rand_mode = 1'b0;
        for (int k = 0; k < N; k++) tx_cnt[k] = 0;
        tx_cnt[0] = 5;
        tx_cnt[1] = 5;
        for (int i = 0; i < 5; i++) begin
            tx_pkts[0][i] = 64'hA000 + 64'(i);
            tx_pkts[1][i] = 64'hB000 + 64'(i);
        end
        rx_n = 10;
        for (int i = 0; i < 10; i++) rx_pkts[i] = 64'(i + 1);
        run_engine(400);

        // Randomized traffic on all requesters with random backpressure.
        rand_mode = 1'b1;
        for (int k = 0; k < N; k++) begin
            tx_cnt[k] = 8;
            for (int i = 0; i < 8; i++) tx_pkts[k][i] = {$urandom(), $urandom()};
        end
        rx_n = 12;
        for (int i = 0; i < 12; i++) rx_pkts[i] = {$urandom(), $urandom()};
        run_engine(3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cardinal_nic_arbiter.md
# cardinal_nic_arbiter

Processor-side access controller for `cardinal_nic`. It shares the NIC's single register port between `NUM_REQ` local transmit requesters using round-robin arbitration, and drains the NIC input buffer into a one-entry receive holding register. It sits between the PE-side clients and the NIC's `addr`/`d_in`/`d_out`/`nicEn`/`nicEnWr` port. It performs at most one NIC register access per cycle.

## Interface
- `DATA_WIDTH`, 64, packet width; status flag is bit `DATA_WIDTH-1`.
- `NUM_REQ`, 4, number of transmit requesters (2..8).
- `clk  in  1`  single clock; all state on posedge.
- `reset  in  1`  synchronous, active-high.
- `req_valid  in  NUM_REQ`  per-requester packet valid. Must hold, with data stable, until the matching `req_ready`.
- `req_data  in  NUM_REQ*DATA_WIDTH`  packed packets; requester k occupies bits `[k*DATA_WIDTH +: DATA_WIDTH]`.
- `req_ready  out  NUM_REQ`  one-hot, one-cycle accept pulse.
- `rx_valid  out  1`  holding register full.
- `rx_data  out  DATA_WIDTH`  received packet.
- `rx_ready  in  1`  consumer accepts; transfer occurs when `rx_valid && rx_ready`.
- `addr  out  2`  NIC register select.
- `d_in  out  DATA_WIDTH`  NIC write data.
- `d_out  in  DATA_WIDTH`  NIC read data. Combinational on `addr` in the same cycle.
- `nicEn  out  1`  NIC access enable.
- `nicEnWr  out  1`  NIC write enable; the write commits at posedge.
- `grant_id  out  $clog2(NUM_REQ)`  index of the last granted requester.

## Operation
- NIC map:
  - `00`: input buffer data. A read with `nicEn=1` and `nicEnWr=0` clears the buffer at the edge.
  - `01`: input status. Bit 63 = 1 means full.
  - `10`: output buffer data (write).
  - `11`: output status. Bit 63 = 1 means full.
- FSM states are `RX_STAT`, `RX_READ`, `TX_STAT` and `TX_WRITE`. Reset state is `RX_STAT`.
- `RX_STAT`: drive `addr=01`, `nicEn=1`.
  - If `d_out[63]=1` and `rx_valid=0`, go to `RX_READ`.
  - Otherwise go to `TX_STAT`.
- `RX_READ`: drive `addr=00`, `nicEn=1`. At the edge, capture `d_out` into `rx_data` and set `rx_valid=1`. Go to `TX_STAT`.
- `TX_STAT`: drive `addr=11`, `nicEn=1`.
  - If `d_out[63]=0` and `|req_valid`, latch the round-robin winner into `gnt` and go to `TX_WRITE`.
  - Otherwise go to `RX_STAT`.
- `TX_WRITE`: drive `addr=10`, `nicEn=1`, `nicEnWr=1`, `d_in=req_data[gnt]`, and `req_ready[gnt]=1`. At the edge, set the pointer to `gnt+1` (mod `NUM_REQ`) and `grant_id=gnt`. Go to `RX_STAT`.
- Round-robin rule: the winner is the first asserted `req_valid` at or after the pointer, wrapping from `NUM_REQ-1` to 0.
- RX holding register:
  - `rx_ready && rx_valid` clears `rx_valid` at the edge.
  - A capture in `RX_READ` is never blocked, because entry to that state requires `rx_valid=0`.
- Idle outputs: `d_in=0`, `nicEnWr=0`, `req_ready=0` in every state except `TX_WRITE`.

## Timing
- Reset values: `rx_valid=0`, `rx_data=0`, `grant_id=0`, pointer `=0`, state `RX_STAT`.
- While `reset=1`, combinationally force `nicEn=0`, `nicEnWr=0`, `req_ready=0`, `addr=00`, `d_in=0`. This prevents a stale NIC write or read-clear during the reset cycle.
- Reset mid-packet: a `TX_WRITE` interrupted by reset produces no NIC write and no `req_ready`. The requester keeps `req_valid` and is re-arbitrated after reset.
- TX latency (both cases assume NIC out-buffer empty):
  - Best case: `req_valid` rising during `RX_STAT` with no RX pending gives `req_ready` in cycle +2.
  - Worst case: 4 cycles for the first grant when the RX path is also taken.
- RX latency: `rx_valid` rises 2 cycles after `RX_STAT` samples the NIC input full.
- Max throughput: one TX packet and one RX packet per 4-cycle round.
- Simultaneous events:
  - RX is serviced before TX within a round.
  - `rx_ready` and an `RX_READ` capture cannot coincide.
  - NIC out-buffer full at `TX_STAT` means no grant, no `req_ready`, and the pointer is unchanged.

## Structure
- `cardinal_nic_pkg`: address constants `NIC_RX_DATA=2'b00`, `NIC_RX_STAT=2'b01`, `NIC_TX_DATA=2'b10`, `NIC_TX_STAT=2'b11`; `STATUS_BIT=63`; FSM state enum.
- Sub-module `rr_arbiter`: combinational winner select from `req_valid` and the pointer, with a `gnt_valid` output. Parameterised by `NUM_REQ`.

## Test plan
- Single requester: reset 4 cycles, NIC out-buffer empty, `req_valid[2]=1`, `req_data[2]=64'h0000_0000_0000_00A5`. Expect one write at `addr=10` with `d_in=64'hA5`, `req_ready=4'b0100` for exactly one cycle, then `grant_id=2`.
- Fairness: all four `req_valid` held high with NIC always empty. Expect grant order 0,1,2,3,0 on successive `TX_WRITE` cycles and no requester granted twice within 4 grants.
- Backpressure: NIC out-status bit 63=1 for 20 cycles with requests pending. Expect no `nicEnWr` and `req_ready=0`. After status clears, the next grant goes to the pointer-first requester.
- RX path: NIC input full with `d_out=64'h1` at `addr=00`, `rx_ready=0`. Expect `rx_valid=1`, `rx_data=64'h1`, and no further `addr=00` read while held. After `rx_ready=1` for one cycle, expect `rx_valid=0` and the next packet read.
- Reset mid-write: assert `reset` in a `TX_WRITE` cycle. Expect `nicEnWr=0` and `req_ready=0` that cycle, state `RX_STAT`, and the pointer back to 0 afterwards.
- Mixed traffic: 10 RX packets (values 1..10) and 10 TX packets from requesters 0/1 alternating. Expect all 20 transferred in order per source with no loss or duplication, checked against a scoreboard.
